i2c_target_eeprom: RTL and testbench

I2C target (slave) that emulates a 256-byte serial EEPROM: 8-bit word address, byte/page write, current-address, random and sequential read. It is the responder for the SoC I2C master. It provides a synthesizable on-chip bus partner for SoC-level simulation and FPGA loopback of the master (scl/sda wired through a pull-up model), and gives the testbench a backdoor port to check memory contents. Everything runs in the system clock domain; SCL and SDA are oversampled.

---
 rtl/i2c_pkg.sv | 30 +++
 rtl/i2c_line_sync.sv | 42 ++++
 rtl/i2c_target_eeprom.sv | 228 ++++++++++++++++++++++
 tb/tb_i2c_target_eeprom.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, R/W bit values and the page-wrap pointer step.
package i2c_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned MEM_DEPTH = 256;

  localparam logic I2C_WR = 1'b0;
  localparam logic I2C_RD = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_DEV       = 4'd1,
    ST_DEV_ACK   = 4'd2,
    ST_WADDR     = 4'd3,
    ST_WADDR_ACK = 4'd4,
    ST_WR        = 4'd5,
    ST_WR_ACK    = 4'd6,
    ST_RD        = 4'd7,
    ST_RD_ACK    = 4'd8
  } i2c_state_e;

  // Advance the in-page offset only; the page number is held.
  function automatic logic [BYTE_W-1:0] page_inc(input logic [BYTE_W-1:0] ptr,
                                                 input int unsigned page_size);
    logic [BYTE_W-1:0] mask;
    mask = BYTE_W'(page_size - 1);
    return (ptr & ~mask) | ((ptr + BYTE_W'(1)) & mask);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronisers for SCL/SDA plus START, STOP and SCL edge detection.
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_c,
  output logic start_c,
  output logic stop_c,
  output logic rise_c,
  output logic fall_c
);

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_prev_q;
  logic       sda_prev_q;
  logic       scl_c;

  // Idle bus is high, so reset to 1 to avoid a false edge on release.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  assign scl_c   = scl_sync_q[1];
  assign sda_c   = sda_sync_q[1];
  assign start_c = scl_c & scl_prev_q & sda_prev_q & ~sda_c;
  assign stop_c  = scl_c & scl_prev_q & ~sda_prev_q & sda_c;
  assign rise_c  = scl_c & ~scl_prev_q;
  assign fall_c  = ~scl_c & scl_prev_q;

endmodule

// File: rtl/i2c_target_eeprom.sv
// I2C target emulating a 256-byte EEPROM with page write, random and sequential read,
// plus a backdoor read port for checking memory contents.
module i2c_target_eeprom
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR  = 7'h50,
  parameter int unsigned PAGE_SIZE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic              busy,
  output logic              wr_pulse,
  output logic [BYTE_W-1:0] wr_addr,
  output logic [BYTE_W-1:0] wr_data,
  input  logic [BYTE_W-1:0] bd_addr,
  output logic [BYTE_W-1:0] bd_data
);

  logic sda_c, start_c, stop_c, rise_c, fall_c;

  i2c_line_sync u_line_sync (
    .clk     (clk),
    .rst     (rst),
    .scl_i   (scl_i),
    .sda_i   (sda_i),
    .sda_c   (sda_c),
    .start_c (start_c),
    .stop_c  (stop_c),
    .rise_c  (rise_c),
    .fall_c  (fall_c)
  );

  logic [BYTE_W-1:0] mem [0:MEM_DEPTH-1];

  i2c_state_e        state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [BYTE_W-1:0] ptr_q, ptr_d;
  logic              rw_q, rw_d;
  logic              ack_ph_q, ack_ph_d;
  logic              sda_oe_q, sda_oe_d;
  logic              busy_q, busy_d;
  logic              wr_pulse_q, wr_pulse_d;
  logic [BYTE_W-1:0] wr_addr_q, wr_addr_d;
  logic [BYTE_W-1:0] wr_data_q, wr_data_d;

  logic [BYTE_W-1:0] byte_in;
  logic [BYTE_W-1:0] rd_byte;

  assign byte_in = {shift_q[BYTE_W-2:0], sda_c};
  assign rd_byte = mem[ptr_q];

  // Line events pre-empt any bit sampling in the same cycle.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    ack_ph_d   = ack_ph_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    if (start_c) begin
      state_d   = ST_DEV;
      bit_cnt_d = 3'd7;
      ack_ph_d  = 1'b0;
      sda_oe_d  = 1'b0;
    end else if (stop_c) begin
      state_d  = ST_IDLE;
      ack_ph_d = 1'b0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ST_DEV: begin
          if (rise_c) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q - 3'd1;
            if (bit_cnt_q == 3'd0) begin
              if (byte_in[BYTE_W-1:1] == DEV_ADDR) begin
                state_d  = ST_DEV_ACK;
                rw_d     = byte_in[0];
                busy_d   = 1'b1;
                ack_ph_d = 1'b0;
              end else begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
              end
            end
          end
        end
        ST_WADDR: begin
          if (rise_c) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q - 3'd1;
            if (bit_cnt_q == 3'd0) begin
              ptr_d    = byte_in;
              state_d  = ST_WADDR_ACK;
              ack_ph_d = 1'b0;
            end
          end
        end
        ST_WR: begin
          if (rise_c) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q - 3'd1;
            if (bit_cnt_q == 3'd0) begin
              wr_pulse_d = 1'b1;
              wr_addr_d  = ptr_q;
              wr_data_d  = byte_in;
              ptr_d      = page_inc(ptr_q, PAGE_SIZE);
              state_d    = ST_WR_ACK;
              ack_ph_d   = 1'b0;
            end
          end
        end
        ST_DEV_ACK, ST_WADDR_ACK, ST_WR_ACK: begin
          // First falling edge starts the ACK, second one ends it.
          if (fall_c) begin
            if (!ack_ph_q) begin
              sda_oe_d = 1'b1;
              ack_ph_d = 1'b1;
            end else begin
              ack_ph_d  = 1'b0;
              bit_cnt_d = 3'd7;
              sda_oe_d  = 1'b0;
              if (state_q == ST_DEV_ACK && rw_q == I2C_RD) begin
                state_d  = ST_RD;
                shift_d  = rd_byte;
                sda_oe_d = ~rd_byte[BYTE_W-1];
              end else if (state_q == ST_DEV_ACK) begin
                state_d = ST_WADDR;
              end else begin
                state_d = ST_WR;
              end
            end
          end
        end
        ST_RD: begin
          if (rise_c) begin
            bit_cnt_d = bit_cnt_q - 3'd1;
            if (bit_cnt_q == 3'd0) begin
              state_d  = ST_RD_ACK;
              ptr_d    = ptr_q + BYTE_W'(1);
              ack_ph_d = 1'b0;
            end
          end else if (fall_c) begin
            shift_d  = {shift_q[BYTE_W-2:0], 1'b0};
            sda_oe_d = ~shift_q[BYTE_W-2];
          end
        end
        ST_RD_ACK: begin
          if (rise_c) begin
            if (sda_c) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end else begin
              ack_ph_d = 1'b1;
            end
          end else if (fall_c) begin
            if (!ack_ph_q) begin
              sda_oe_d = 1'b0;
            end else begin
              state_d   = ST_RD;
              ack_ph_d  = 1'b0;
              bit_cnt_d = 3'd7;
              shift_d   = rd_byte;
              sda_oe_d  = ~rd_byte[BYTE_W-1];
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd7;
      shift_q    <= '0;
      ptr_q      <= '0;
      rw_q       <= I2C_WR;
      ack_ph_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      ack_ph_q   <= ack_ph_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_pulse_q <= wr_pulse_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Array update trails the strobe so a same-cycle backdoor read sees the old byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) mem[BYTE_W'(i)] <= '0;
    end else if (wr_pulse_q) begin
      mem[wr_addr_q] <= wr_data_q;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign busy     = busy_q;
  assign wr_pulse = wr_pulse_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign bd_data  = mem[bd_addr];

endmodule

// File: tb/tb_i2c_target_eeprom.sv
// Bench for i2c_target_eeprom: bit-banged I2C master, transaction-level EEPROM model.
module tb_i2c_target_eeprom;

  localparam int unsigned Q    = 6;
  localparam int unsigned PAGE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_oe, busy, wr_pulse;
  logic [7:0] wr_addr, wr_data, bd_addr, bd_data;
  logic       sda_line;

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_eeprom #(.DEV_ADDR(7'h50), .PAGE_SIZE(PAGE)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_m),
    .sda_i    (sda_line),
    .sda_oe   (sda_oe),
    .busy     (busy),
    .wr_pulse (wr_pulse),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .bd_addr  (bd_addr),
    .bd_data  (bd_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  ref_mem [256];
  logic [7:0]  ref_ptr;
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  logic [7:0]  bd_at_pulse = 8'h00;
  logic [7:0]  bd_after_pulse = 8'h00;
  bit          pulse_last = 1'b0;
  bit          oe_seen = 1'b0;

  typedef struct {
    logic [7:0] dev;
    logic [7:0] waddr;
    logic [7:0] data;
  } vec_t;

  always @(negedge clk) begin
    if (pulse_last) bd_after_pulse = bd_data;
    pulse_last = wr_pulse;
    if (wr_pulse) begin
      got_q.push_back({wr_addr, wr_data});
      bd_at_pulse = bd_data;
    end
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  task automatic wq(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; scl_m = 1'b1; wq(Q);
    sda_m = 1'b0; wq(Q);
    scl_m = 1'b0; wq(Q);
  endtask

  task automatic bus_rstart();
    sda_m = 1'b1; wq(Q);
    scl_m = 1'b1; wq(Q);
    sda_m = 1'b0; wq(Q);
    scl_m = 1'b0; wq(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wq(Q);
    scl_m = 1'b1; wq(Q);
    sda_m = 1'b1; wq(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; wq(Q);
    scl_m = 1'b1; wq(2 * Q);
    scl_m = 1'b0; wq(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wq(Q);
    scl_m = 1'b1; wq(Q);
    b = sda_line; wq(Q);
    scl_m = 1'b0; wq(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    chk("sda released after 8th read bit", sda_oe, 0);
    write_bit(nack);
  endtask

  // Reference model: byte commit with in-page wrap, read with 8-bit wrap.
  task automatic m_commit(input logic [7:0] d);
    int p;
    p = int'(ref_ptr);
    ref_mem[ref_ptr] = d;
    exp_q.push_back({ref_ptr, d});
    p = (p / PAGE) * PAGE + (p + 1) % PAGE;
    ref_ptr = 8'(p);
  endtask

  task automatic m_read(output logic [7:0] d);
    d = ref_mem[ref_ptr];
    ref_ptr = 8'((int'(ref_ptr) + 1) % 256);
  endtask

  task automatic check_commits();
    logic [15:0] g, e;
    chk("commit count", got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk("commit addr/data", g, e);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [7:0] data[$]);
    logic ack;
    bus_start();
    write_byte(8'hA0, ack); chk("wr dev ack", ack, 1);
    write_byte(addr, ack);  chk("wr waddr ack", ack, 1);
    ref_ptr = addr;
    foreach (data[i]) begin
      write_byte(data[i], ack); chk("wr data ack", ack, 1);
      m_commit(data[i]);
    end
    bus_stop(); wq(4);
    check_commits();
    chk("busy after write stop", busy, 0);
  endtask

  task automatic do_read(input logic [7:0] addr, input int len, input bit random_rd,
                         output logic [7:0] first);
    logic ack;
    logic [7:0] d, e;
    if (random_rd) begin
      bus_start();
      write_byte(8'hA0, ack); chk("rd dev-w ack", ack, 1);
      write_byte(addr, ack);  chk("rd waddr ack", ack, 1);
      ref_ptr = addr;
      bus_rstart();
    end else begin
      bus_start();
    end
    write_byte(8'hA1, ack); chk("rd dev-r ack", ack, 1);
    chk("busy during read", busy, 1);
    first = 8'h00;
    for (int i = 0; i < len; i++) begin
      read_byte(d, (i == len - 1));
      m_read(e);
      chk("read data", d, e);
      if (i == 0) first = d;
    end
    bus_stop(); wq(4);
    chk("busy after read stop", busy, 0);
    check_commits();
  endtask

  task automatic bd_chk(input string name, input logic [7:0] a, input logic [7:0] want);
    bd_addr = a; wq(1);
    chk(name, bd_data, want);
  endtask

  initial begin
    vec_t       vt [6];
    logic       ack, exp_ack, got_oe;
    logic [7:0] first, old;
    logic [7:0] dq[$];

    vt[0] = '{dev: 8'hA0, waddr: 8'h12, data: 8'h5A};
    vt[1] = '{dev: 8'hA2, waddr: 8'h33, data: 8'h77};
    vt[2] = '{dev: 8'hA0, waddr: 8'h80, data: 8'hC3};
    vt[3] = '{dev: 8'hA4, waddr: 8'h10, data: 8'h01};
    vt[4] = '{dev: 8'hA0, waddr: 8'hEF, data: 8'hEE};
    vt[5] = '{dev: 8'h20, waddr: 8'h12, data: 8'hFF};

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    ref_ptr = 8'h00;
    bd_addr = 8'h00;

    wq(4);
    rst = 1'b0;
    wq(2);
    chk("reset sda_oe", sda_oe, 0);
    chk("reset busy", busy, 0);
    chk("reset wr_pulse", wr_pulse, 0);
    chk("reset wr_addr", wr_addr, 0);
    chk("reset wr_data", wr_data, 0);
    chk("reset mem", bd_data, 0);

    // Table: single-byte writes, some to foreign device addresses.
    for (int i = 0; i < 6; i++) begin
      exp_ack = (vt[i].dev[7:1] == 7'h50) && (vt[i].dev[0] == 1'b0);
      bd_addr = vt[i].waddr;
      old     = ref_mem[vt[i].waddr];
      oe_seen = 1'b0;
      bus_start();
      write_byte(vt[i].dev, ack);
      chk("table dev ack", ack, exp_ack);
      if (exp_ack) begin
        chk("table busy", busy, 1);
        write_byte(vt[i].waddr, ack); chk("table waddr ack", ack, 1);
        ref_ptr = vt[i].waddr;
        write_byte(vt[i].data, ack);  chk("table data ack", ack, 1);
        m_commit(vt[i].data);
      end else begin
        write_byte(vt[i].waddr, ack);
        chk("table foreign sda_oe", oe_seen, 0);
        chk("table foreign busy", busy, 0);
      end
      bus_stop(); wq(4);
      check_commits();
      chk("table busy after stop", busy, 0);
      if (exp_ack) begin
        chk("table bd same cycle old", bd_at_pulse, old);
        chk("table bd next cycle new", bd_after_pulse, vt[i].data);
      end
    end
    bd_chk("byte write bd 0x12", 8'h12, 8'h5A);

    // Page wrap from 0x06.
    dq = '{8'h11, 8'h22, 8'h33};
    do_write(8'h06, dq);
    bd_chk("page wrap 0x06", 8'h06, 8'h11);
    bd_chk("page wrap 0x07", 8'h07, 8'h22);
    bd_chk("page wrap 0x04", 8'h04, 8'h33);

    // Random read of the byte-write location.
    do_read(8'h12, 1, 1'b1, first);
    chk("random read 0x12", first, 8'h5A);

    // Sequential current-address read across the 0xFF->0x00 boundary.
    dq = '{8'h01, 8'h02, 8'h03, 8'h04};
    do_write(8'hFE, dq);
    bd_chk("seq page wrap 0xFC", 8'hFC, 8'h03);
    do_read(8'h00, 3, 1'b0, first);
    chk("seq read first", first, 8'h01);

    // Abort mid data byte: no commit, next transfer normal.
    bus_start();
    write_byte(8'hA0, ack); chk("abort dev ack", ack, 1);
    write_byte(8'h30, ack); chk("abort waddr ack", ack, 1);
    ref_ptr = 8'h30;
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    bus_stop(); wq(4);
    chk("abort no commit", got_q.size(), 0);
    chk("abort busy", busy, 0);
    dq = '{8'h99};
    do_write(8'h31, dq);
    bd_chk("abort mem 0x30 untouched", 8'h30, ref_mem[8'h30]);
    bd_chk("after abort 0x31", 8'h31, 8'h99);

    // Randomised transactions against the model.
    for (int t = 0; t < 20; t++) begin
      int op, len;
      op  = int'($urandom_range(0, 2));
      len = int'($urandom_range(1, 5));
      if (op == 0) begin
        dq.delete();
        for (int k = 0; k < len; k++) dq.push_back(8'($urandom));
        do_write(8'($urandom), dq);
      end else begin
        do_read(8'($urandom), len, (op == 1), first);
      end
    end
    for (int a = 0; a < 256; a++) bd_chk("backdoor sweep", 8'(a), ref_mem[a]);

    // Reset while the target drives the address ACK.
    bus_start();
    for (int i = 7; i >= 0; i--) write_bit(((8'hA0 >> i) & 8'h01) != 8'h00);
    sda_m  = 1'b1;
    got_oe = 1'b0;
    for (int k = 0; k < 50 && !got_oe; k++) begin
      got_oe = sda_oe;
      if (!got_oe) wq(1);
    end
    chk("ack driven before rst", got_oe, 1);
    rst = 1'b1;
    wq(1);
    chk("rst releases sda", sda_oe, 0);
    chk("rst clears busy", busy, 0);
    rst = 1'b0;
    wq(2);
    bus_stop(); wq(4);
    got_q.delete();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    ref_ptr = 8'h00;
    bd_chk("rst clears mem 0x12", 8'h12, 8'h00);
    bd_chk("rst clears mem 0x06", 8'h06, 8'h00);
    dq = '{8'hA5, 8'h5A};
    do_write(8'h40, dq);
    do_read(8'h40, 2, 1'b1, first);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
